// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared 7-segment font and display geometry constants
package seven_seg_pkg;

    localparam int DIGIT_COUNT = 4;
    localparam int NIBBLE_W    = 4;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex n.
    // Packed array, so the leftmost literal is entry 15.
    localparam logic [15:0][7:0] SEG_FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    function automatic logic [7:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
        return SEG_FONT[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational hex nibble to active-low 7-segment decoder
//   i_nibble : hex value to show
//   o_seg    : active-low segments, bit0=a .. bit6=g, bit7=dp (always off)
module seg7_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nibble,
    output logic [7:0]          o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/updown_counter_display_top.sv
// rtl/updown_counter_display_top.sv - 16-bit hex up/down counter with buzzer and 4-digit muxed display
//   clk_50MHz : board clock, all logic on rising edge
//   reset     : synchronous active-high reset
//   stop      : freeze count and prescaler
//   load      : force count to LOAD_VALUE (overrides stop)
//   updown    : 1 = count up, 0 = count down, sampled at the tick
//   buzzer    : high while the wrap pulse timer is running
//   seg       : active-low segments of the selected digit
//   digit     : active-low digit enables, digit[0] = least-significant nibble
module updown_counter_display_top
    import seven_seg_pkg::*;
#(
    parameter int          TICK_DIV    = 50_000_000,
    parameter int          SCAN_DIV    = 50_000,
    parameter int          BUZZ_CYCLES = 25_000_000,
    parameter logic [15:0] LOAD_VALUE  = 16'h1234
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       stop,
    input  logic       load,
    input  logic       updown,
    output logic       buzzer,
    output logic [7:0] seg,
    output logic [3:0] digit
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BUZZ_CYCLES + 1);
    localparam int IW = $clog2(DIGIT_COUNT);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGIT_COUNT - 1);

    logic [15:0]   r_count;
    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_scan_cnt;
    logic [IW-1:0] r_idx;
    logic [BW-1:0] r_buzz;

    logic                w_tick;
    logic                w_step;
    logic                w_wrap;
    logic [NIBBLE_W-1:0] w_nibble;
    logic [3:0]          w_onehot;

    assign w_tick = (r_presc == PRESC_MAX);
    // A step only happens when neither load nor stop is holding the counter.
    assign w_step = w_tick && !load && !stop;
    assign w_wrap = w_step && (updown ? (r_count == 16'hFFFF) : (r_count == 16'h0000));

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_count    <= 16'h0000;
            r_presc    <= '0;
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_buzz     <= '0;
        end else begin
            // Display scan runs regardless of load/stop.
            if (r_scan_cnt == SCAN_MAX) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            // A new wrap restarts the pulse even if one is already running.
            if (w_wrap) begin
                r_buzz <= BUZZ_LOAD;
            end else if (r_buzz != '0) begin
                r_buzz <= r_buzz - 1'b1;
            end

            if (load) begin
                r_count <= LOAD_VALUE;
                r_presc <= '0;
            end else if (!stop) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_count <= updown ? (r_count + 16'd1) : (r_count - 16'd1);
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    assign buzzer   = (r_buzz != '0);
    assign w_onehot = 4'b0001 << r_idx;
    assign digit    = ~w_onehot;
    assign w_nibble = r_count[r_idx*NIBBLE_W +: NIBBLE_W];

    seg7_hex_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (seg)
    );

endmodule

// File: tb/tb_updown_counter_display_top.sv
// tb/tb_updown_counter_display_top.sv - directed self-checking bench for updown_counter_display_top
module tb_updown_counter_display_top;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stop = 1'b1;
    logic       load = 1'b0;
    logic       updown = 1'b1;
    logic       buzzer;
    logic [7:0] seg;
    logic [3:0] digit;

    int n_pass = 0;
    int n_total = 0;

    updown_counter_display_top #(
        .TICK_DIV    (4),
        .SCAN_DIV    (2),
        .BUZZ_CYCLES (8),
        .LOAD_VALUE  (16'h1234)
    ) dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .stop      (stop),
        .load      (load),
        .updown    (updown),
        .buzzer    (buzzer),
        .seg       (seg),
        .digit     (digit)
    );

    always #10 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the edge for sampling/driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [7:0] exp_seg;
        logic [3:0] seen;

        // Reset held 5 cycles with stop=1.
        step(5);
        check("rst_count", dut.r_count, 32'h0000);
        check("rst_buzzer", buzzer, 0);
        check("rst_digit", digit, 4'b1110);
        check("rst_seg", seg, 8'hC0);

        // Release: first up step lands TICK_DIV cycles later.
        reset = 0; stop = 0; updown = 1;
        step(3);
        check("count_pre_tick", dut.r_count, 32'h0000);
        step(1);
        check("count_first_tick", dut.r_count, 32'h0001);
        step(8);
        check("count_after_12", dut.r_count, 32'h0003);

        // Load then freeze; scan all four digits of 1234.
        load = 1;
        step(2);
        load = 0; stop = 1;
        check("load_value", dut.r_count, 32'h1234);
        seen = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step(1);
            case (digit)
                4'b1110: exp_seg = 8'h99;
                4'b1101: exp_seg = 8'hB0;
                4'b1011: exp_seg = 8'hA4;
                4'b0111: exp_seg = 8'hF9;
                default: exp_seg = 8'h00;
            endcase
            check("digit_onehot", $countones(~digit), 1);
            check("scan_seg", seg, exp_seg);
            seen = seen | ~digit;
        end
        check("scan_all_digits", seen, 4'b1111);
        check("stop_hold", dut.r_count, 32'h1234);

        // Down wrap: reset, one up step to 0001, then count down 0000 -> FFFF.
        reset = 1;
        step(1);
        reset = 0; stop = 0; updown = 1;
        step(4);
        check("to_0001", dut.r_count, 32'h0001);
        updown = 0;
        step(4);
        check("down_0000", dut.r_count, 32'h0000);
        check("no_buzz_0000", buzzer, 0);
        step(3);
        check("buzz_before_wrap", buzzer, 0);
        step(1);
        check("down_wrap", dut.r_count, 32'h0000FFFF);
        check("buzz_rise_dn", buzzer, 1);
        stop = 1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check("buzz_len_dn", buzzer, (i < 8) ? 1 : 0);
            check("seg_F", seg, 8'h8E);
        end

        // Up wrap FFFF -> 0000, then a down wrap 4 cycles into the pulse restarts it.
        stop = 0; updown = 1;
        step(3);
        check("up_pre_wrap", dut.r_count, 32'h0000FFFF);
        step(1);
        check("up_wrap", dut.r_count, 32'h0000);
        check("buzz_rise_up", buzzer, 1);
        updown = 0;
        step(3);
        check("buzz_mid_pulse", buzzer, 1);
        step(1);
        check("second_wrap", dut.r_count, 32'h0000FFFF);
        stop = 1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check("buzz_extend", buzzer, (i < 8) ? 1 : 0);
        end

        // Stop mid-prescale: prescaler at 2, frozen 10 cycles, then 2 more cycles to the tick.
        stop = 0; updown = 1;
        step(2);
        stop = 1;
        step(10);
        check("stop_mid_count", dut.r_count, 32'h0000FFFF);
        stop = 0;
        step(1);
        check("resume_pre_tick", dut.r_count, 32'h0000FFFF);
        step(1);
        check("resume_tick", dut.r_count, 32'h0000);

        // load beats stop; reset beats load.
        load = 1; stop = 1;
        step(1);
        check("load_over_stop", dut.r_count, 32'h1234);
        reset = 1;
        step(1);
        check("reset_over_load", dut.r_count, 32'h0000);

        // Reset in the middle of a buzzer pulse.
        reset = 0; load = 0; stop = 0; updown = 0;
        step(4);
        check("wrap_for_reset", dut.r_count, 32'h0000FFFF);
        step(2);
        check("buzz_before_rst", buzzer, 1);
        reset = 1;
        step(1);
        check("rst_mid_buzzer", buzzer, 0);
        check("rst_mid_count", dut.r_count, 32'h0000);
        check("rst_mid_digit", digit, 4'b1110);
        check("rst_mid_seg", seg, 8'hC0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
